c2f_consumer: RTL and testbench
===============================

Name: c2f_consumer

Overview:
- FPGA-side consumer of the CPU->FPGA (C2F) chunk queue.
- Host burst-writes chunks into the C2F buffer RAM and advances the C2F_WRPTR register.
- This block drains those chunks from the RAM at a programmable rate, folds every quadword into a 64-bit checksum, and publishes its read pointer. The read pointer goes to the metrics DMA, which writes it back to host memory as the C2F read pointer.

Parameters:
- CHUNK_QWS_LOG2, 9: log2 of quadwords per chunk (9 = 4096-byte chunk).
- NUM_CHUNKS_LOG2, 2: log2 of chunks in the C2F ring (2 = 4 chunks; 3 usable).
- RATE_WIDTH, 16: width of the rate register and of the phase accumulator.

Ports:
- clk_in, input, 1: PCIe application clock.
- rstn, input, 1: asynchronous, active-low reset.
- softReset_in, input, 1: synchronous clear, asserted while DMA_ENABLE is written 0; same effect as rstn.
- wrPtr_in, input, NUM_CHUNKS_LOG2: host write pointer (C2F_WRPTR register).
- rate_in, input, RATE_WIDTH: CONSUMER_RATE register; 0 = consumer paused.
- ramAddr_out, output, NUM_CHUNKS_LOG2+CHUNK_QWS_LOG2: C2F RAM quadword address, {chunk, qwIndex}.
- ramRdEn_out, output, 1: RAM read strobe.
- ramData_in, input, 64: RAM read data, valid exactly 1 cycle after ramRdEn_out.
- rdPtr_out, output, NUM_CHUNKS_LOG2: index of the next chunk not yet fully consumed.
- checksum_out, output, 64: running sum of consumed quadwords, mod 2^64.
- busy_out, output, 1: high while a read is issued or data is outstanding.

Behaviour:
Reset values:
- rstn low (async) or softReset_in high (at the clock edge) clears all outputs and all state to 0.
- This includes: rdPtr_out, checksum_out, ramAddr_out, ramRdEn_out, busy_out, issue pointer, qwIndex, phase accumulator, in-flight flag.
- Reset mid-chunk discards the partial chunk; the returned data of a read issued in the cycle before reset is ignored.

Pacing:
- phase accumulator acc[RATE_WIDTH-1:0].
- Each cycle, acc <= acc + rate_in; the carry-out is the token.
- rate_in=0 means no tokens; acc holds.
- Token rate = rate_in/2^RATE_WIDTH QWs per cycle. Example: rate 256 gives one QW per 256 cycles.
- A rate change takes effect on the next add; acc is not cleared.

Issue:
- Internal issue chunk pointer issChunk and qwIndex.
- Data available when issChunk != wrPtr_in.
- On a token cycle with data available: ramRdEn_out=1 and ramAddr_out={issChunk, qwIndex} on the registered output in the following cycle.
- After the issue, qwIndex increments. On qwIndex = 2^CHUNK_QWS_LOG2-1 it wraps to 0 and issChunk increments, wrapping mod 2^NUM_CHUNKS_LOG2.
- A token with no data available is dropped; it is not banked.
- At most one read per cycle.

Accumulate:
- The cycle after ramRdEn_out: checksum_out <= checksum_out + ramData_in (64-bit wrap, carry discarded).
- A delayed flag marks whether that quadword was the last of its chunk.

Read pointer:
- rdPtr_out increments (mod 2^NUM_CHUNKS_LOG2) in the same cycle the last QW of a chunk is accumulated.
- So rdPtr_out moves 2 cycles after the last ramRdEn_out of that chunk.
- rdPtr_out never passes wrPtr_in.

Full/empty:
- Queue full/empty policing is host-side (host never writes wrPtr to rdPtr-1+1).
- Empty (issChunk == wrPtr_in) stalls issue only.
- A wrPtr_in change is seen the next cycle.

Simultaneous events:
- softReset_in has priority over issue and accumulate.
- rate_in -> 0 mid-chunk: any in-flight QW still accumulates; position is kept; consumption resumes there when the rate becomes nonzero.

busy_out = ramRdEn_out | accumulate-pending.

Test Plan:
- Reset values: rstn low then high, wrPtr_in=0, rate_in=0xFFFF -> no ramRdEn_out for 1000 cycles; rdPtr_out=0, checksum_out=0.
- Single chunk: chunk 0 RAM QW[i]=i+1 (i=0..511), wrPtr_in=1, rate_in=0xFFFF -> exactly 512 reads at addresses 0..511; checksum_out=0x20100; rdPtr_out=1 two cycles after the last read; no further reads.
- Pacing: rate_in=256, chunk available -> consecutive ramRdEn_out exactly 256 cycles apart. Then set rate_in=0x8000 -> reads every 2 cycles. Then set rate_in=0 mid-chunk -> reads stop, qwIndex held; set rate_in=0x8000 again -> resumes at the next address with no skipped or repeated QW.
- Ring wrap: 4-chunk ring; host fills 3 chunks (wrPtr_in 0->3), drains; then 3 more (wrPtr_in 3->2 via wrap) -> rdPtr_out sequence 1,2,3,0,1,2; ramAddr_out chunk field wraps 3->0; checksum equals the software model sum mod 2^64 (include QWs 0xFFFFFFFFFFFFFFFF to force wrap).
- Mid-operation reset: assert softReset_in at qwIndex=100 of chunk 1 with a read in flight -> next cycle all outputs 0; the in-flight data does not change checksum_out. Repeat with async rstn pulsed between clock edges -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/c2f_consumer.sv
// C2F chunk-queue consumer: paces quadword reads out of the C2F buffer RAM,
// folds each returned quadword into a 64-bit checksum and publishes rdPtr.
module c2f_consumer #(
  parameter int CHUNK_QWS_LOG2  = 9,
  parameter int NUM_CHUNKS_LOG2 = 2,
  parameter int RATE_WIDTH      = 16
) (
  input  logic                                      clk_in,
  input  logic                                      rstn,
  input  logic                                      softReset_in,
  input  logic [NUM_CHUNKS_LOG2-1:0]                wrPtr_in,
  input  logic [RATE_WIDTH-1:0]                     rate_in,
  output logic [NUM_CHUNKS_LOG2+CHUNK_QWS_LOG2-1:0] ramAddr_out,
  output logic                                      ramRdEn_out,
  input  logic [63:0]                               ramData_in,
  output logic [NUM_CHUNKS_LOG2-1:0]                rdPtr_out,
  output logic [63:0]                               checksum_out,
  output logic                                      busy_out
);

  localparam logic [CHUNK_QWS_LOG2-1:0]  QW_ONE    = CHUNK_QWS_LOG2'(1);
  localparam logic [NUM_CHUNKS_LOG2-1:0] CHUNK_ONE = NUM_CHUNKS_LOG2'(1);

  // Checksum overflow policy: plain modulo-2^64 wrap, carry discarded.
  function automatic logic [63:0] sum_wrap(input logic [63:0] a, input logic [63:0] b);
    return a + b;
  endfunction

  logic [RATE_WIDTH-1:0]      acc_p0;
  logic [RATE_WIDTH:0]        acc_sum_p0;
  logic [NUM_CHUNKS_LOG2-1:0] iss_chunk_p0;
  logic [CHUNK_QWS_LOG2-1:0]  qw_idx_p0;
  logic                       token_p0;
  logic                       avail_p0;
  logic                       issue_p0;
  logic                       last_qw_p0;
  logic                       vld_p1;
  logic                       last_p1;
  logic                       vld_p2;
  logic                       last_p2;

  // Stage 0: phase accumulator carry is the token; issue only when data exists.
  always_comb begin
    acc_sum_p0 = {1'b0, acc_p0} + {1'b0, rate_in};
    token_p0   = acc_sum_p0[RATE_WIDTH];
    avail_p0   = (iss_chunk_p0 != wrPtr_in);
    issue_p0   = token_p0 & avail_p0;
    last_qw_p0 = &qw_idx_p0;
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      acc_p0       <= '0;
      iss_chunk_p0 <= '0;
      qw_idx_p0    <= '0;
      ramAddr_out  <= '0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
      vld_p2       <= 1'b0;
      last_p2      <= 1'b0;
      checksum_out <= '0;
      rdPtr_out    <= '0;
    end else if (softReset_in) begin
      acc_p0       <= '0;
      iss_chunk_p0 <= '0;
      qw_idx_p0    <= '0;
      ramAddr_out  <= '0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
      vld_p2       <= 1'b0;
      last_p2      <= 1'b0;
      checksum_out <= '0;
      rdPtr_out    <= '0;
    end else begin
      acc_p0 <= acc_sum_p0[RATE_WIDTH-1:0];

      // Stage 1: registered RAM read strobe and address.
      vld_p1  <= issue_p0;
      last_p1 <= issue_p0 & last_qw_p0;
      if (issue_p0) begin
        ramAddr_out <= {iss_chunk_p0, qw_idx_p0};
        qw_idx_p0   <= qw_idx_p0 + QW_ONE;
        if (last_qw_p0) begin
          iss_chunk_p0 <= iss_chunk_p0 + CHUNK_ONE;
        end
      end

      // Stage 2: RAM data is valid now; accumulate and retire the chunk.
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      if (vld_p2) begin
        checksum_out <= sum_wrap(checksum_out, ramData_in);
        if (last_p2) begin
          rdPtr_out <= rdPtr_out + CHUNK_ONE;
        end
      end
    end
  end

  assign ramRdEn_out = vld_p1;
  assign busy_out    = vld_p1 | vld_p2;

endmodule

// File: tb/tb_c2f_consumer.sv
// Bench for c2f_consumer: behavioural RAM, reference model of read order,
// checksum and read-pointer sequence, and scenario tasks.
module tb_c2f_consumer;

  logic        clk_in       = 1'b0;
  logic        rstn         = 1'b0;
  logic        softReset_in = 1'b0;
  logic [1:0]  wrPtr_in     = 2'd0;
  logic [15:0] rate_in      = 16'd0;
  logic [10:0] ramAddr_out;
  logic        ramRdEn_out;
  logic [63:0] ramData_in;
  logic [1:0]  rdPtr_out;
  logic [63:0] checksum_out;
  logic        busy_out;

  int n_tests = 0;
  int n_fail  = 0;

  c2f_consumer #(
    .CHUNK_QWS_LOG2 (9),
    .NUM_CHUNKS_LOG2(2),
    .RATE_WIDTH     (16)
  ) dut (
    .clk_in      (clk_in),
    .rstn        (rstn),
    .softReset_in(softReset_in),
    .wrPtr_in    (wrPtr_in),
    .rate_in     (rate_in),
    .ramAddr_out (ramAddr_out),
    .ramRdEn_out (ramRdEn_out),
    .ramData_in  (ramData_in),
    .rdPtr_out   (rdPtr_out),
    .checksum_out(checksum_out),
    .busy_out    (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // C2F buffer RAM: one-cycle read latency
  logic [63:0] mem [0:2047];
  logic [63:0] ram_q;
  always @(posedge clk_in) if (ramRdEn_out) ram_q <= mem[ramAddr_out];
  assign ramData_in = ram_q;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int rst_evt = 0;
  always @(posedge clk_in or negedge rstn)
    if (!rstn || softReset_in) rst_evt <= rst_evt + 1;

  // Reference model: the n-th read after reset must hit quadword n of the ring,
  // the checksum is the sum of all quadwords read, rdPtr changes are logged.
  int          seen_evt    = 0;
  int          rd_count    = 0;
  int          addr_errs   = 0;
  int          last_rd_cyc = 0;
  int          rp_cyc      = 0;
  logic [63:0] exp_sum     = 64'd0;
  logic [1:0]  prev_rp     = 2'd0;
  int          rp_q[$];

  initial forever begin
    @(negedge clk_in);
    if (rst_evt != seen_evt) begin
      seen_evt = rst_evt;
      rd_count = 0;
      exp_sum  = 64'd0;
      prev_rp  = 2'd0;
    end
    if (ramRdEn_out === 1'b1) begin
      if (ramAddr_out !== 11'(rd_count)) addr_errs++;
      exp_sum     = exp_sum + mem[ramAddr_out];
      rd_count    = rd_count + 1;
      last_rd_cyc = cyc;
    end
    if (rdPtr_out !== prev_rp) begin
      prev_rp = rdPtr_out;
      rp_q.push_back(int'(rdPtr_out));
      rp_cyc = cyc;
    end
  end

  task automatic sample();
    @(negedge clk_in);
    #1;
  endtask

  task automatic drive();
    @(posedge clk_in);
    #1;
  endtask

  task automatic fill_chunk(input int chunk, input bit with_ones);
    for (int i = 0; i < 512; i++) begin
      if (with_ones && (i % 7 == 3)) mem[chunk*512 + i] = '1;
      else mem[chunk*512 + i] = {32'($urandom), 32'($urandom)};
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; softReset_in = 1'b0; wrPtr_in = 2'd0; rate_in = 16'hFFFF;
    repeat (3) @(posedge clk_in);
    #1;
    n_tests++; if (ramRdEn_out !== 1'b0) begin n_fail++; $display("FAIL reset_rden: got %0b want 0", ramRdEn_out); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_out); end
    n_tests++; if (ramAddr_out !== 11'd0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", ramAddr_out); end
    n_tests++; if (rdPtr_out !== 2'd0) begin n_fail++; $display("FAIL reset_rdptr: got %0d want 0", rdPtr_out); end
    n_tests++; if (checksum_out !== 64'd0) begin n_fail++; $display("FAIL reset_checksum: got %0h want 0", checksum_out); end
    rstn = 1'b1;
    repeat (1000) sample();
    n_tests++; if (rd_count !== 0) begin n_fail++; $display("FAIL empty_no_reads: got %0d reads want 0", rd_count); end
    n_tests++; if (rdPtr_out !== 2'd0) begin n_fail++; $display("FAIL empty_rdptr: got %0d want 0", rdPtr_out); end
    n_tests++; if (checksum_out !== 64'd0) begin n_fail++; $display("FAIL empty_checksum: got %0h want 0", checksum_out); end
  endtask

  task automatic test_single_chunk();
    int t;
    for (int i = 0; i < 512; i++) mem[i] = 64'(i + 1);
    drive();
    wrPtr_in = 2'd1;
    t = 0;
    while (rdPtr_out !== 2'd1 && t < 3000) begin sample(); t++; end
    n_tests++; if (rdPtr_out !== 2'd1) begin n_fail++; $display("FAIL single_rdptr: got %0d want 1", rdPtr_out); end
    n_tests++; if (rp_cyc - last_rd_cyc !== 2) begin n_fail++; $display("FAIL single_rdptr_lag: got %0d want 2", rp_cyc - last_rd_cyc); end
    repeat (100) sample();
    n_tests++; if (rd_count !== 512) begin n_fail++; $display("FAIL single_reads: got %0d want 512", rd_count); end
    n_tests++; if (addr_errs !== 0) begin n_fail++; $display("FAIL single_addr_order: got %0d errors want 0", addr_errs); end
    n_tests++; if (checksum_out !== 64'h20100) begin n_fail++; $display("FAIL single_checksum: got %0h want 20100", checksum_out); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %0b want 0", busy_out); end
  endtask

  task automatic test_pacing();
    int tr[6];
    int base;
    int t;
    int hold;
    fill_chunk(1, 1'b0);
    drive();
    rate_in = 16'd256; wrPtr_in = 2'd2;
    for (int k = 0; k < 5; k++) begin
      base = rd_count; t = 0;
      while (rd_count == base && t < 400) begin sample(); t++; end
      tr[k] = last_rd_cyc;
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (tr[k+1] - tr[k] !== 256) begin n_fail++; $display("FAIL pace_256_gap%0d: got %0d want 256", k, tr[k+1] - tr[k]); end
    end
    drive();
    rate_in = 16'h8000;
    for (int k = 0; k < 6; k++) begin
      base = rd_count; t = 0;
      while (rd_count == base && t < 300) begin sample(); t++; end
      tr[k] = last_rd_cyc;
    end
    for (int k = 1; k < 5; k++) begin
      n_tests++;
      if (tr[k+1] - tr[k] !== 2) begin n_fail++; $display("FAIL pace_half_gap%0d: got %0d want 2", k, tr[k+1] - tr[k]); end
    end
    drive();
    rate_in = 16'd0;
    repeat (3) sample();
    hold = rd_count;
    repeat (60) sample();
    n_tests++; if (rd_count !== hold) begin n_fail++; $display("FAIL pause_reads: got %0d want %0d", rd_count, hold); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL pause_busy: got %0b want 0", busy_out); end
    drive();
    rate_in = 16'h8000;
    t = 0;
    while (rdPtr_out !== 2'd2 && t < 2000) begin sample(); t++; end
    repeat (3) sample();
    n_tests++; if (rdPtr_out !== 2'd2) begin n_fail++; $display("FAIL pace_rdptr: got %0d want 2", rdPtr_out); end
    n_tests++; if (rd_count !== 1024) begin n_fail++; $display("FAIL pace_reads: got %0d want 1024", rd_count); end
    n_tests++; if (addr_errs !== 0) begin n_fail++; $display("FAIL pace_addr_order: got %0d errors want 0", addr_errs); end
    n_tests++; if (checksum_out !== exp_sum) begin n_fail++; $display("FAIL pace_checksum: got %0h want %0h", checksum_out, exp_sum); end
  endtask

  task automatic test_ring_wrap();
    int qsz;
    int t;
    int r;
    int c0;
    int n;
    int lo;
    int want[6];
    want = '{1, 2, 3, 0, 1, 2};
    drive();
    softReset_in = 1'b1; wrPtr_in = 2'd0; rate_in = 16'd0;
    drive();
    softReset_in = 1'b0;
    sample();
    n_tests++; if (rdPtr_out !== 2'd0) begin n_fail++; $display("FAIL soft_rdptr: got %0d want 0", rdPtr_out); end
    n_tests++; if (checksum_out !== 64'd0) begin n_fail++; $display("FAIL soft_checksum: got %0h want 0", checksum_out); end
    qsz = rp_q.size();
    fill_chunk(0, 1'b1); fill_chunk(1, 1'b1); fill_chunk(2, 1'b1);
    r = int'($urandom_range(16'hFFFF, 16'h4000));
    drive();
    wrPtr_in = 2'd3; rate_in = 16'(r);
    repeat (5) sample();
    c0 = rd_count;
    repeat (500) sample();
    n = rd_count - c0;
    lo = (500 * r) >> 16;
    n_tests++;
    if (n < lo || n > lo + 1) begin n_fail++; $display("FAIL rand_rate_%0h: got %0d reads want %0d..%0d", r, n, lo, lo + 1); end
    drive();
    rate_in = 16'hFFFF;
    t = 0;
    while (rdPtr_out !== 2'd3 && t < 3000) begin sample(); t++; end
    fill_chunk(3, 1'b1); fill_chunk(0, 1'b1); fill_chunk(1, 1'b1);
    drive();
    wrPtr_in = 2'd2;
    t = 0;
    while (rdPtr_out !== 2'd2 && t < 3000) begin sample(); t++; end
    repeat (5) sample();
    n_tests++;
    if (rp_q.size() !== qsz + 6) begin n_fail++; $display("FAIL ring_rdptr_count: got %0d want 6", rp_q.size() - qsz); end
    else begin
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (rp_q[qsz + k] !== want[k]) begin n_fail++; $display("FAIL ring_rdptr_%0d: got %0d want %0d", k, rp_q[qsz + k], want[k]); end
      end
    end
    n_tests++; if (rd_count !== 3072) begin n_fail++; $display("FAIL ring_reads: got %0d want 3072", rd_count); end
    n_tests++; if (addr_errs !== 0) begin n_fail++; $display("FAIL ring_addr_order: got %0d errors want 0", addr_errs); end
    n_tests++; if (checksum_out !== exp_sum) begin n_fail++; $display("FAIL ring_checksum: got %0h want %0h", checksum_out, exp_sum); end
  endtask

  task automatic test_mid_reset();
    int t;
    drive();
    softReset_in = 1'b1; wrPtr_in = 2'd0; rate_in = 16'd0;
    drive();
    softReset_in = 1'b0;
    fill_chunk(0, 1'b0); fill_chunk(1, 1'b0);
    drive();
    wrPtr_in = 2'd2; rate_in = 16'hFFFF;
    t = 0;
    while (!(ramRdEn_out === 1'b1 && ramAddr_out === 11'd612) && t < 2000) begin sample(); t++; end
    n_tests++; if (ramAddr_out !== 11'd612) begin n_fail++; $display("FAIL midsoft_reach: got %0h want 264", ramAddr_out); end
    softReset_in = 1'b1; rate_in = 16'd0;
    @(posedge clk_in);
    #1;
    softReset_in = 1'b0;
    n_tests++; if (ramRdEn_out !== 1'b0) begin n_fail++; $display("FAIL midsoft_rden: got %0b want 0", ramRdEn_out); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL midsoft_busy: got %0b want 0", busy_out); end
    n_tests++; if (ramAddr_out !== 11'd0) begin n_fail++; $display("FAIL midsoft_addr: got %0h want 0", ramAddr_out); end
    n_tests++; if (rdPtr_out !== 2'd0) begin n_fail++; $display("FAIL midsoft_rdptr: got %0d want 0", rdPtr_out); end
    n_tests++; if (checksum_out !== 64'd0) begin n_fail++; $display("FAIL midsoft_checksum: got %0h want 0", checksum_out); end
    repeat (3) sample();
    n_tests++; if (checksum_out !== 64'd0) begin n_fail++; $display("FAIL midsoft_inflight: got %0h want 0", checksum_out); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL midsoft_busy_after: got %0b want 0", busy_out); end

    drive();
    rate_in = 16'hFFFF;
    t = 0;
    while (!(ramRdEn_out === 1'b1 && ramAddr_out === 11'd612) && t < 2000) begin sample(); t++; end
    n_tests++; if (ramAddr_out !== 11'd612) begin n_fail++; $display("FAIL midasync_reach: got %0h want 264", ramAddr_out); end
    @(posedge clk_in);
    #2;
    rstn = 1'b0;
    #1;
    n_tests++; if (ramRdEn_out !== 1'b0) begin n_fail++; $display("FAIL async_rden: got %0b want 0", ramRdEn_out); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %0b want 0", busy_out); end
    n_tests++; if (ramAddr_out !== 11'd0) begin n_fail++; $display("FAIL async_addr: got %0h want 0", ramAddr_out); end
    n_tests++; if (rdPtr_out !== 2'd0) begin n_fail++; $display("FAIL async_rdptr: got %0d want 0", rdPtr_out); end
    n_tests++; if (checksum_out !== 64'd0) begin n_fail++; $display("FAIL async_checksum: got %0h want 0", checksum_out); end
    rate_in = 16'd0;
    @(posedge clk_in);
    #1;
    rstn = 1'b1;
    repeat (3) sample();
    n_tests++; if (checksum_out !== 64'd0) begin n_fail++; $display("FAIL async_after_checksum: got %0h want 0", checksum_out); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL async_after_busy: got %0b want 0", busy_out); end
  endtask

  initial begin
    test_reset();
    test_single_chunk();
    test_pacing();
    test_ring_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
